// File: rtl/vfu_slot_request_arbiter_pkg.sv
// Shared types and constants for the VFU slot request arbiter.
// slot_req_t is the flattened SlotRequestToVFU payload; the arbiter treats it as opaque bits.
package vfu_arb_pkg;

    typedef struct packed {
        logic [31:0] src0;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] src3;
        logic [7:0]  opcode;
        logic [31:0] mask;
        logic [5:0]  ctrl;
        logic [31:0] tag;
    } slot_req_t;

    localparam int SLOT_REQ_W = $bits(slot_req_t);
    localparam int BUF_DEPTH  = 2;
    localparam int PERF_CNT_W = 32;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vfu_slot_request_arbiter_if.sv
// Request/response bundle between the lane slot stages and the arbiter.
// master: request side (drives valids, payloads and out_ready); slave: the arbiter.
interface vfu_slot_request_arbiter_if
    import vfu_arb_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int PAYLOAD_W = SLOT_REQ_W,
    parameter int SRC_W     = src_width(NUM_IN)
);
    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN-1:0]           in_ready;
    logic [NUM_IN*PAYLOAD_W-1:0] in_bits;
    logic                        out_valid;
    logic                        out_ready;
    logic [PAYLOAD_W-1:0]        out_bits;
    logic [SRC_W-1:0]            out_source;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_bits, out_source
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_bits, out_source
    );
endinterface

// File: rtl/vfu_slot_request_arbiter_rr_grant.sv
// Pointer-rotated priority picker: first requester at or after i_ptr (mod NUM_IN).
// Purely combinational; produces a one-hot grant, its index and an any-request flag.
module rr_grant #(
    parameter int NUM_IN = 4,
    parameter int SRC_W  = 2
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [SRC_W-1:0]  i_ptr,
    output logic [NUM_IN-1:0] o_gnt,
    output logic [SRC_W-1:0]  o_idx,
    output logic              o_any
);
    int w_cand;

    // Scan offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NUM_IN) begin
                w_cand = w_cand - NUM_IN;
            end
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = SRC_W'(w_cand);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_onehot
        assign o_gnt[gi] = o_any && (o_idx == SRC_W'(gi));
    end

endmodule

// File: rtl/vfu_slot_request_arbiter.sv
// N-input round-robin arbiter feeding one VFU through a registered 2-entry skid buffer.
// in_ready never depends on out_ready: it is derived only from the buffer count.
// Optional macro VFU_ARB_PERF_EN adds per-channel accept counters and a stall counter.
module vfu_slot_request_arbiter
    import vfu_arb_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int PAYLOAD_W = SLOT_REQ_W,
    parameter int SRC_W     = src_width(NUM_IN)
) (
    input  logic clock,
    input  logic reset,
    vfu_slot_request_arbiter_if.slave io
`ifdef VFU_ARB_PERF_EN
    ,
    output logic [NUM_IN*PERF_CNT_W-1:0] perf_accept_cnt,
    output logic [PERF_CNT_W-1:0]        perf_stall_cnt
`endif
);
    logic [1:0]           r_count;
    logic [SRC_W-1:0]     r_ptr;
    logic [PAYLOAD_W-1:0] r_head_bits;
    logic [SRC_W-1:0]     r_head_src;
    logic [PAYLOAD_W-1:0] r_tail_bits;
    logic [SRC_W-1:0]     r_tail_src;
    logic                 r_rst_d;

    logic [NUM_IN-1:0]    w_gnt;
    logic [SRC_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_space;
    logic                 w_accept;
    logic                 w_deq;
    logic [PAYLOAD_W-1:0] w_in_bits;
    logic [SRC_W-1:0]     w_ptr_next;

    rr_grant #(
        .NUM_IN (NUM_IN),
        .SRC_W  (SRC_W)
    ) u_rr_grant (
        .i_req  (io.in_valid),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Grants are suppressed during reset and the cycle after it.
    assign w_space    = !reset && !r_rst_d && (r_count < 2'(BUF_DEPTH));
    assign w_accept   = w_any && w_space;
    assign w_deq      = (r_count != 2'd0) && io.out_ready;
    assign w_in_bits  = io.in_bits[w_idx*PAYLOAD_W +: PAYLOAD_W];
    assign w_ptr_next = (w_idx == SRC_W'(NUM_IN - 1)) ? '0 : w_idx + SRC_W'(1);

    assign io.in_ready   = w_space ? w_gnt : '0;
    assign io.out_valid  = (r_count != 2'd0);
    assign io.out_bits   = r_head_bits;
    assign io.out_source = r_head_src;

    // Round-robin pointer and skid buffer update; count=2 blocks enqueue so 2'b11 only occurs at count=1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= '0;
            r_ptr       <= '0;
            r_head_bits <= '0;
            r_head_src  <= '0;
            r_tail_bits <= '0;
            r_tail_src  <= '0;
            r_rst_d     <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
            case ({w_accept, w_deq})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_bits <= w_in_bits;
                        r_head_src  <= w_idx;
                    end else begin
                        r_tail_bits <= w_in_bits;
                        r_tail_src  <= w_idx;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head_bits <= r_tail_bits;
                    r_head_src  <= r_tail_src;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head_bits <= w_in_bits;
                    r_head_src  <= w_idx;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef VFU_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_acc_cnt
        logic [PERF_CNT_W-1:0] r_cnt;

        // Saturating count of accepts from this channel.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_accept && w_gnt[gi] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign perf_accept_cnt[gi*PERF_CNT_W +: PERF_CNT_W] = r_cnt;
    end

    // Saturating count of cycles where the VFU back-pressures a valid head.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (io.out_valid && !io.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vfu_slot_request_arbiter.sv
// Self-checking bench for vfu_slot_request_arbiter with a queue-based reference model.
module tb_vfu_slot_request_arbiter;
    import vfu_arb_pkg::*;

    localparam int N  = 4;
    localparam int PW = SLOT_REQ_W;
    localparam int SW = 2;

    logic clk;
    logic rst;

    vfu_slot_request_arbiter_if #(.NUM_IN(N), .PAYLOAD_W(PW), .SRC_W(SW)) bus ();

`ifdef VFU_ARB_PERF_EN
    logic [N*32-1:0] perf_accept_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    vfu_slot_request_arbiter #(.NUM_IN(N), .PAYLOAD_W(PW), .SRC_W(SW)) dut (
        .clock           (clk),
        .reset           (rst),
        .io              (bus.slave)
`ifdef VFU_ARB_PERF_EN
        ,
        .perf_accept_cnt (perf_accept_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] pay [N];

    typedef struct {
        logic [PW-1:0] bits;
        logic [SW-1:0] src;
    } ent_t;

    ent_t          m_q[$];
    int            m_ptr = 0;
    int            m_post_rst = 0;
    int            m_win;
    logic [N-1:0]  exp_ready;
    logic          exp_valid;
    logic [PW-1:0] exp_bits;
    logic [SW-1:0] exp_src;

    function automatic logic [PW-1:0] rand_pay();
        logic [PW-1:0] p;
        p = '0;
        for (int w = 0; w < 7; w++) p = {p[PW-33:0], 32'($urandom)};
        return p;
    endfunction

    task automatic new_payloads();
        for (int i = 0; i < N; i++) pay[i] = rand_pay();
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        bus.in_valid  = v;
        bus.out_ready = r;
        for (int i = 0; i < N; i++) bus.in_bits[i*PW +: PW] = pay[i];
    endtask

    // Reference: first valid channel from ptr (mod N); granted if buffer holds < 2 and not in reset window.
    task automatic model_eval();
        m_win = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_win < 0 && bus.in_valid[c]) m_win = c;
        end
        exp_ready = '0;
        if (!rst && m_post_rst == 0 && m_q.size() < 2 && m_win >= 0) exp_ready[m_win] = 1'b1;
        exp_valid = (m_q.size() != 0);
        exp_bits  = '0;
        exp_src   = '0;
        if (exp_valid) begin
            exp_bits = m_q[0].bits;
            exp_src  = m_q[0].src;
        end
    endtask

    task automatic model_clock();
        ent_t e;
        model_eval();
        if (rst) begin
            m_q.delete();
            m_ptr = 0;
            m_post_rst = 1;
        end else begin
            m_post_rst = 0;
            if (exp_valid && bus.out_ready) void'(m_q.pop_front());
            if (exp_ready != '0) begin
                e.bits = pay[m_win];
                e.src  = SW'(m_win);
                m_q.push_back(e);
                m_ptr = (m_win + 1) % N;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic test_reset();
        new_payloads();
        rst = 1'b1;
        drive('1, 1'b1);
        tick();
        tick();
        settle();
        checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_bits !== '0) begin errors++; $display("FAIL rst_out_bits got=%h exp=0", bus.out_bits); end
        checks++; if (bus.out_source !== '0) begin errors++; $display("FAIL rst_out_source got=%0d exp=0", bus.out_source); end
        tick();
        rst = 1'b0;
        settle();
        checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=0", bus.in_ready); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  e_rdy;
        logic [SW-1:0] e_src;
        new_payloads();
        drive('1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            settle();
            e_rdy = N'(1) << (k % N);
            checks++; if (bus.in_ready !== e_rdy) begin errors++; $display("FAIL rr_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, e_rdy); end
            if (k > 0) begin
                e_src = SW'((k - 1) % N);
                checks++; if (bus.out_source !== e_src || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_out_source k=%0d got=%0d/%b exp=%0d/1", k, bus.out_source, bus.out_valid, e_src); end
                checks++; if (bus.out_bits !== pay[(k - 1) % N]) begin errors++; $display("FAIL rr_out_bits k=%0d got=%h exp=%h", k, bus.out_bits, pay[(k - 1) % N]); end
            end
            tick();
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0]  e_rdy;
        logic [SW-1:0] e_src;
        drive('0, 1'b1);
        tick();
        new_payloads();
        drive(4'b1010, 1'b1);
        for (int k = 0; k < 6; k++) begin
            settle();
            e_rdy = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++; if (bus.in_ready !== e_rdy) begin errors++; $display("FAIL sparse_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, e_rdy); end
            if (k > 0) begin
                e_src = (k % 2 == 1) ? SW'(1) : SW'(3);
                checks++; if (bus.out_source !== e_src) begin errors++; $display("FAIL sparse_out_source k=%0d got=%0d exp=%0d", k, bus.out_source, e_src); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        drive('0, 1'b1);
        tick();
        new_payloads();
        drive('1, 1'b0);
        settle();
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL stall_first_grant got=%b exp=0001", bus.in_ready); end
        tick();
        settle();
        checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL stall_second_grant got=%b exp=0010", bus.in_ready); end
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL stall_full_ready k=%0d got=%b exp=0", k, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_bits !== pay[0] || bus.out_source !== SW'(0)) begin errors++; $display("FAIL stall_head_hold k=%0d got=%h src=%0d exp=%h src=0", k, bus.out_bits, bus.out_source, pay[0]); end
            tick();
        end
        drive('0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_bits !== pay[k] || bus.out_source !== SW'(k)) begin errors++; $display("FAIL stall_drain k=%0d got=%h src=%0d exp=%h src=%0d", k, bus.out_bits, bus.out_source, pay[k], k); end
            tick();
        end
        settle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_simul();
        new_payloads();
        drive(4'b0100, 1'b1);
        settle();
        checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL simul_grant2 got=%b exp=0100", bus.in_ready); end
        tick();
        drive(4'b1000, 1'b1);
        settle();
        checks++; if (bus.in_ready !== 4'b1000 || bus.out_bits !== pay[2]) begin errors++; $display("FAIL simul_head2 rdy=%b got=%h exp=%h", bus.in_ready, bus.out_bits, pay[2]); end
        tick();
        drive('0, 1'b1);
        settle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bits !== pay[3] || bus.out_source !== SW'(3)) begin errors++; $display("FAIL simul_head3 valid=%b got=%h src=%0d exp=%h src=3", bus.out_valid, bus.out_bits, bus.out_source, pay[3]); end
        tick();
        settle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL simul_count_one got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        new_payloads();
        drive('1, 1'b0);
        tick();
        tick();
        settle();
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== '0) begin errors++; $display("FAIL midrst_full valid=%b rdy=%b exp=1/0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive('1, 1'b1);
        settle();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== '0) begin errors++; $display("FAIL midrst_cleared valid=%b rdy=%b exp=0/0", bus.out_valid, bus.in_ready); end
        tick();
        settle();
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got=%b exp=0001", bus.in_ready); end
        tick();
        settle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_source !== SW'(0) || bus.out_bits !== pay[0]) begin errors++; $display("FAIL midrst_first_out src=%0d got=%h exp=%h", bus.out_source, bus.out_bits, pay[0]); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) new_payloads();
            drive(N'($urandom), ($urandom_range(0, 9) < 7));
            settle();
            checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, exp_ready); end
            checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL rand_out_valid k=%0d got=%b exp=%b", k, bus.out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (bus.out_bits !== exp_bits || bus.out_source !== exp_src) begin errors++; $display("FAIL rand_head k=%0d got=%h src=%0d exp=%h src=%0d", k, bus.out_bits, bus.out_source, exp_bits, exp_src); end
            end
            tick();
        end
    endtask

`ifdef VFU_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        drive('0, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        new_payloads();
        drive(4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        drive('0, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        drive('0, 1'b1);
        tick();
        settle();
        checks++; if (perf_stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_stall got=%0d exp=10", perf_stall_cnt); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (perf_accept_cnt[i*32 +: 32] !== ((i == 2) ? 32'd3 : 32'd0)) begin
                errors++;
                $display("FAIL perf_accept ch=%0d got=%0d exp=%0d", i, perf_accept_cnt[i*32 +: 32], (i == 2) ? 3 : 0);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.in_valid  = '0;
        bus.in_bits   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_sparse();
        test_stall();
        test_simul();
        test_reset_mid();
        test_random();
`ifdef VFU_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
